// File: rtl/mme_pkg.sv
// Shared constants, types and helpers for the MME processing-element array.
package mme_pkg;

    localparam int MME_DW_DEF = 16;
    localparam int MME_AW_DEF = 2 * MME_DW_DEF + 8;
    localparam int MME_MAXW   = 128;

    typedef enum logic {
        PE_WRAP = 1'b0,
        PE_SAT  = 1'b1
    } pe_mode_t;

    // Largest representable accumulator value for a width/signedness pair.
    function automatic logic [MME_MAXW-1:0] f_sat_max(input int unsigned aw, input bit sgn);
        logic [MME_MAXW-1:0] one;
        one = {{(MME_MAXW-1){1'b0}}, 1'b1};
        return (one << (sgn ? aw - 1 : aw)) - one;
    endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational AW-bit adder with overflow flag and optional clamp to the AW range.
module pe_sat_add
    import mme_pkg::*;
#(
    parameter int AW     = MME_AW_DEF,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT    = 1'b1
) (
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    output logic [AW-1:0] sum_o,
    output logic          ovf_o
);

    localparam pe_mode_t        MODE  = SAT ? PE_SAT : PE_WRAP;
    localparam logic [AW-1:0]   MAX_V = AW'(f_sat_max(AW, SIGNED));
    localparam logic [AW-1:0]   MIN_V = SIGNED ? ~MAX_V : '0;

    logic [AW:0] ext;

    always_comb begin
        if (SIGNED) begin
            ext   = {a_i[AW-1], a_i} + {b_i[AW-1], b_i};
            ovf_o = ext[AW] ^ ext[AW-1];
        end else begin
            ext   = {1'b0, a_i} + {1'b0, b_i};
            ovf_o = ext[AW];
        end
        sum_o = ext[AW-1:0];
        // The extra carry bit tells which rail a signed overflow went past.
        if (ovf_o && MODE == PE_SAT)
            sum_o = (SIGNED && ext[AW]) ? MIN_V : MAX_V;
    end

endmodule

// File: rtl/mac_pe_v2.sv
// Systolic MAC PE: forwards operands east/south, accumulates valid beats, and
// double-buffers finished tiles onto a result drain chain.
module mac_pe_v2
    import mme_pkg::*;
#(
    parameter int DW     = MME_DW_DEF,
    parameter int AW     = 2 * DW + 8,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          hold_i,
    input  logic          vld_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          vld_o,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    input  logic          swap_i,
    input  logic          shift_i,
    input  logic [AW-1:0] res_i,
    input  logic          rvld_i,
    output logic [AW-1:0] res_o,
    output logic          rvld_o,
    output logic          ovf_o
);

    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic          vld_q, vld_d;
    logic [AW-1:0] acc_q, acc_d, res_q, res_d;
    logic          rvld_q, rvld_d, ovf_q, ovf_d;

    logic [2*DW-1:0] prod_n;
    logic [AW-1:0]   prod;
    logic [AW-1:0]   sum;
    logic            add_ovf;
    logic            beat;

    assign beat = vld_i & ~hold_i;

    generate
        if (SIGNED) begin : g_sprod
            assign prod_n = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
            assign prod   = {{(AW-2*DW){prod_n[2*DW-1]}}, prod_n};
        end else begin : g_uprod
            assign prod_n = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
            assign prod   = {{(AW-2*DW){1'b0}}, prod_n};
        end
    endgenerate

    pe_sat_add #(
        .AW     (AW),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (prod),
        .sum_o (sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        vld_d  = vld_q;
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        res_d  = res_q;
        rvld_d = rvld_q;

        if (!hold_i) begin
            a_d   = a_i;
            b_d   = b_i;
            vld_d = vld_i;
        end
        if (beat) begin
            acc_d = sum;
            ovf_d = ovf_q | add_ovf;
        end
        // Swap snapshots the pre-update accum; a same-cycle beat seeds the next tile.
        if (swap_i) begin
            res_d  = acc_q;
            rvld_d = 1'b1;
            ovf_d  = 1'b0;
            acc_d  = beat ? prod : '0;
        end else if (shift_i) begin
            res_d  = res_i;
            rvld_d = rvld_i;
        end
        if (clr_i) begin
            a_d   = '0;
            b_d   = '0;
            vld_d = 1'b0;
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            vld_q  <= 1'b0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            res_q  <= '0;
            rvld_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            vld_q  <= vld_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            res_q  <= res_d;
            rvld_q <= rvld_d;
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign vld_o  = vld_q;
    assign res_o  = res_q;
    assign rvld_o = rvld_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_mac_pe_v2.sv
// Bench for mac_pe_v2: four configurations on shared stimulus, checked against an
// arithmetic model of the accumulate / swap / drain rules.
module tb_mac_pe_v2;

    logic clk = 1'b0;
    logic rst, clr, hold, vld, swap, shift, rvld_in;
    logic [15:0] a, b;
    logic [39:0] res_in40;
    logic [32:0] res_in33;

    logic [15:0] d_a[4], d_b[4];
    logic        d_vld[4], d_rvld[4], d_ovf[4];
    logic [39:0] d_res[4];
    logic [39:0] r40_0, r40_3;
    logic [32:0] r33_1, r33_2;

    int checks = 0;
    int failures = 0;

    // model: 0=AW40 signed sat, 1=AW33 signed sat, 2=AW33 signed wrap, 3=AW40 unsigned sat
    int     m_aw[4] = '{40, 33, 33, 40};
    bit     m_sg[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit     m_st[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    longint m_acc[4], m_res[4];
    bit     m_ovf[4], m_rvld[4];
    logic [15:0] m_a, m_b;
    bit     m_vld;

    always #5 clk = ~clk;

    mac_pe_v2 #(.DW(16), .AW(40), .SIGNED(1'b1), .SAT(1'b1)) u0 (
        .clk(clk), .rst(rst), .clr_i(clr), .hold_i(hold), .vld_i(vld), .a_i(a), .b_i(b),
        .vld_o(d_vld[0]), .a_o(d_a[0]), .b_o(d_b[0]), .swap_i(swap), .shift_i(shift),
        .res_i(res_in40), .rvld_i(rvld_in), .res_o(r40_0), .rvld_o(d_rvld[0]), .ovf_o(d_ovf[0]));
    mac_pe_v2 #(.DW(16), .AW(33), .SIGNED(1'b1), .SAT(1'b1)) u1 (
        .clk(clk), .rst(rst), .clr_i(clr), .hold_i(hold), .vld_i(vld), .a_i(a), .b_i(b),
        .vld_o(d_vld[1]), .a_o(d_a[1]), .b_o(d_b[1]), .swap_i(swap), .shift_i(shift),
        .res_i(res_in33), .rvld_i(rvld_in), .res_o(r33_1), .rvld_o(d_rvld[1]), .ovf_o(d_ovf[1]));
    mac_pe_v2 #(.DW(16), .AW(33), .SIGNED(1'b1), .SAT(1'b0)) u2 (
        .clk(clk), .rst(rst), .clr_i(clr), .hold_i(hold), .vld_i(vld), .a_i(a), .b_i(b),
        .vld_o(d_vld[2]), .a_o(d_a[2]), .b_o(d_b[2]), .swap_i(swap), .shift_i(shift),
        .res_i(res_in33), .rvld_i(rvld_in), .res_o(r33_2), .rvld_o(d_rvld[2]), .ovf_o(d_ovf[2]));
    mac_pe_v2 #(.DW(16), .AW(40), .SIGNED(1'b0), .SAT(1'b1)) u3 (
        .clk(clk), .rst(rst), .clr_i(clr), .hold_i(hold), .vld_i(vld), .a_i(a), .b_i(b),
        .vld_o(d_vld[3]), .a_o(d_a[3]), .b_o(d_b[3]), .swap_i(swap), .shift_i(shift),
        .res_i(res_in40), .rvld_i(rvld_in), .res_o(r40_3), .rvld_o(d_rvld[3]), .ovf_o(d_ovf[3]));

    assign d_res[0] = r40_0;
    assign d_res[1] = {7'd0, r33_1};
    assign d_res[2] = {7'd0, r33_2};
    assign d_res[3] = r40_3;

    function automatic longint mask(int aw);
        return (longint'(1) << aw) - 1;
    endfunction

    // Update the model with the inputs that were present at the clock edge.
    function automatic void model_step();
        longint p, s, lo, hi, sa, sb, rin;
        bit beat;
        beat = vld && !hold;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                m_acc[k] = 0; m_res[k] = 0; m_ovf[k] = 0; m_rvld[k] = 0;
                continue;
            end
            if (m_sg[k]) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                lo = -(longint'(1) << (m_aw[k] - 1));
                hi = (longint'(1) << (m_aw[k] - 1)) - 1;
            end else begin
                sa = longint'(a); sb = longint'(b);
                lo = 0;
                hi = mask(m_aw[k]);
            end
            p = sa * sb;
            rin = (m_aw[k] == 40) ? longint'(res_in40) : longint'(res_in33);
            if (swap) begin
                m_res[k]  = m_acc[k] & mask(m_aw[k]);
                m_rvld[k] = 1;
                m_ovf[k]  = 0;
                m_acc[k]  = (beat && !clr) ? p : 0;
            end else begin
                if (beat) begin
                    s = m_acc[k] + p;
                    if (s > hi || s < lo) begin
                        m_ovf[k] = 1;
                        if (m_st[k]) s = (s > hi) ? hi : lo;
                        else begin
                            s = s & mask(m_aw[k]);
                            if (m_sg[k] && s > hi) s = s - (longint'(1) << m_aw[k]);
                        end
                    end
                    m_acc[k] = s;
                end
                if (shift) begin
                    m_res[k]  = rin & mask(m_aw[k]);
                    m_rvld[k] = rvld_in;
                end
            end
            if (clr) begin
                m_acc[k] = 0; m_ovf[k] = 0;
            end
        end
        if (rst || clr) begin
            m_a = '0; m_b = '0; m_vld = 0;
        end else if (!hold) begin
            m_a = a; m_b = b; m_vld = vld;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; clr = 0; hold = 0; vld = 0; swap = 0; shift = 0; rvld_in = 0;
        a = '0; b = '0; res_in40 = '0; res_in33 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        vld = 1; a = 16'h1234; b = 16'h5678; swap = 1;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_res[k] !== 40'd0 || d_rvld[k] !== 1'b0 || d_ovf[k] !== 1'b0 ||
                d_vld[k] !== 1'b0 || d_a[k] !== 16'd0 || d_b[k] !== 16'd0) begin
                failures++;
                $display("FAIL reset[%0d] res=%h rvld=%b ovf=%b vld=%b a=%h b=%h exp all 0",
                         k, d_res[k], d_rvld[k], d_ovf[k], d_vld[k], d_a[k], d_b[k]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_basic();
        idle_inputs();
        vld = 1; a = 16'd3; b = 16'hFFFE;
        repeat (4) tick();
        checks++;
        if (d_a[0] !== 16'd3 || d_b[0] !== 16'hFFFE || d_vld[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_fwd a=%h b=%h vld=%b exp 0003 fffe 1", d_a[0], d_b[0], d_vld[0]);
        end
        vld = 0; swap = 1;
        tick();
        checks++;
        if (r40_0 !== 40'hFF_FFFF_FFE8 || d_rvld[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_res got %h rvld=%b exp ffffffffe8 1", r40_0, d_rvld[0]);
        end
        checks++;
        if (r33_1 !== 33'h1_FFFF_FFE8 || r40_3 !== 40'h00_000B_FFE8) begin
            failures++;
            $display("FAIL basic_cfg u1=%h u3=%h exp 1ffffffe8 00000bffe8", r33_1, r40_3);
        end
        tick();
        checks++;
        if (r40_0 !== 40'd0) begin
            failures++;
            $display("FAIL basic_restart got %h exp 0", r40_0);
        end
        swap = 0;
    endtask

    task automatic test_hold_idle();
        idle_inputs();
        vld = 1; a = 16'd2; b = 16'd5; tick();
        vld = 0; a = 16'd9; b = 16'd9; tick();
        checks++;
        if (d_a[0] !== 16'd9 || d_vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL idle_load a=%h vld=%b exp 0009 0", d_a[0], d_vld[0]);
        end
        hold = 1; vld = 1; a = 16'd7; b = 16'd7; tick();
        checks++;
        if (d_a[0] !== 16'd9 || d_b[0] !== 16'd9 || d_vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL hold_freeze a=%h b=%h vld=%b exp 0009 0009 0", d_a[0], d_b[0], d_vld[0]);
        end
        hold = 0; a = 16'd1; b = 16'd4; tick();
        vld = 0; swap = 1; tick();
        checks++;
        if (r40_0 !== 40'd14 || r40_3 !== 40'd14) begin
            failures++;
            $display("FAIL hold_res u0=%h u3=%h exp 14", r40_0, r40_3);
        end
        swap = 0;
    endtask

    task automatic test_sat();
        idle_inputs();
        clr = 1; tick(); clr = 0;
        vld = 1; a = 16'h8000; b = 16'h8000;
        repeat (3) tick();
        checks++;
        if (d_ovf[1] !== 1'b0 || d_ovf[2] !== 1'b0) begin
            failures++;
            $display("FAIL sat_pre ovf1=%b ovf2=%b exp 0 0", d_ovf[1], d_ovf[2]);
        end
        tick();
        checks++;
        if (d_ovf[1] !== 1'b1 || d_ovf[2] !== 1'b1 || d_ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL sat_ovf ovf1=%b ovf2=%b ovf0=%b exp 1 1 0", d_ovf[1], d_ovf[2], d_ovf[0]);
        end
        tick();
        vld = 0; swap = 1; tick(); swap = 0;
        checks++;
        if (r33_1 !== 33'h0_FFFF_FFFF) begin
            failures++;
            $display("FAIL sat_clamp got %h exp 0ffffffff", r33_1);
        end
        checks++;
        if (r33_2 !== 33'h1_4000_0000) begin
            failures++;
            $display("FAIL wrap_val got %h exp 140000000", r33_2);
        end
        checks++;
        if (d_ovf[1] !== 1'b0 || d_ovf[2] !== 1'b0 || r40_0 !== 40'h01_4000_0000) begin
            failures++;
            $display("FAIL sat_swap ovf1=%b ovf2=%b u0=%h exp 0 0 0140000000", d_ovf[1], d_ovf[2], r40_0);
        end
    endtask

    task automatic test_swap_vld();
        logic [39:0] sv[3];
        logic        rv[3];
        idle_inputs();
        sv[0] = 40'hA; sv[1] = 40'hB; sv[2] = 40'hC;
        rv[0] = 1'b1; rv[1] = 1'b0; rv[2] = 1'b1;
        vld = 1; a = 16'd4; b = 16'd4; tick(); tick();
        swap = 1; a = 16'd5; b = 16'd7; tick();
        checks++;
        if (r40_0 !== 40'd32) begin
            failures++;
            $display("FAIL swapv_old got %h exp 32", r40_0);
        end
        swap = 0; vld = 0; shift = 1;
        for (int i = 0; i < 3; i++) begin
            res_in40 = sv[i]; rvld_in = rv[i];
            tick();
            checks++;
            if (r40_0 !== sv[i] || d_rvld[0] !== rv[i]) begin
                failures++;
                $display("FAIL shift[%0d] got %h rvld=%b exp %h %b", i, r40_0, d_rvld[0], sv[i], rv[i]);
            end
        end
        shift = 0; res_in40 = 40'h55; rvld_in = 0; tick();
        checks++;
        if (r40_0 !== 40'hC || d_rvld[0] !== 1'b1) begin
            failures++;
            $display("FAIL shift_idle got %h rvld=%b exp c 1", r40_0, d_rvld[0]);
        end
        swap = 1; tick(); swap = 0;
        checks++;
        if (r40_0 !== 40'd35) begin
            failures++;
            $display("FAIL swapv_new got %h exp 35", r40_0);
        end
    endtask

    task automatic test_unsigned();
        idle_inputs();
        vld = 1; a = 16'hFFFF; b = 16'hFFFF; tick();
        vld = 0; swap = 1; tick(); swap = 0;
        checks++;
        if (r40_3 !== 40'h00_FFFE_0001 || r40_0 !== 40'd1) begin
            failures++;
            $display("FAIL unsigned u3=%h u0=%h exp 00fffe0001 1", r40_3, r40_0);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        vld = 1; a = 16'd11; b = 16'd13; tick();
        shift = 1; res_in40 = 40'h77; rvld_in = 1; rst = 1; tick();
        idle_inputs();
        checks++;
        if (r40_0 !== 40'd0 || d_rvld[0] !== 1'b0 || d_a[0] !== 16'd0 || d_vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid res=%h rvld=%b a=%h vld=%b exp 0", r40_0, d_rvld[0], d_a[0], d_vld[0]);
        end
        vld = 1; a = 16'd3; b = 16'd3; tick();
        swap = 1; vld = 0; tick(); swap = 0;
        clr = 1; vld = 1; a = 16'd6; b = 16'd6; tick(); clr = 0; vld = 0;
        checks++;
        if (r40_0 !== 40'd9 || d_rvld[0] !== 1'b1 || d_a[0] !== 16'd0 || d_vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_keep res=%h rvld=%b a=%h vld=%b exp 9 1 0 0", r40_0, d_rvld[0], d_a[0], d_vld[0]);
        end
        swap = 1; tick(); swap = 0;
        checks++;
        if (r40_0 !== 40'd0) begin
            failures++;
            $display("FAIL clr_discard got %h exp 0", r40_0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            clr      = ($urandom_range(0, 31) == 0);
            hold     = ($urandom_range(0, 7) == 0);
            vld      = ($urandom_range(0, 3) != 0);
            swap     = ($urandom_range(0, 11) == 0);
            shift    = !swap && ($urandom_range(0, 2) == 0);
            rvld_in  = $urandom_range(0, 1);
            a        = 16'($urandom);
            b        = 16'($urandom);
            res_in40 = {8'($urandom), 32'($urandom)};
            res_in33 = {1'($urandom), 32'($urandom)};
            tick();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (d_res[k] !== 40'(m_res[k]) || d_rvld[k] !== m_rvld[k] || d_ovf[k] !== m_ovf[k]) begin
                    failures++;
                    $display("FAIL rand_res[%0d] cyc %0d res=%h rvld=%b ovf=%b exp %h %b %b",
                             k, c, d_res[k], d_rvld[k], d_ovf[k], 40'(m_res[k]), m_rvld[k], m_ovf[k]);
                end
                checks++;
                if (d_a[k] !== m_a || d_b[k] !== m_b || d_vld[k] !== m_vld) begin
                    failures++;
                    $display("FAIL rand_fwd[%0d] cyc %0d a=%h b=%h vld=%b exp %h %h %b",
                             k, c, d_a[k], d_b[k], d_vld[k], m_a, m_b, m_vld);
                end
            end
        end
        idle_inputs();
        swap = 1; tick(); swap = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_res[k] !== 40'(m_res[k])) begin
                failures++;
                $display("FAIL rand_final[%0d] got %h exp %h", k, d_res[k], 40'(m_res[k]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_idle();
        test_sat();
        test_swap_vld();
        test_unsigned();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
